sdm_dac_bank: RTL and testbench

- Parametrised multi-channel DAC output stage for the multisound CPLD/FPGA. It generalises the fixed 4-channel, 8-bit, 6-bit-volume DAC path.
- Each channel takes a sample and a volume from a single shared write port.
- Output is a 1-bit first-order sigma-delta stream, gated by a volume PWM.
- New relative to the fixed path: selectable sample format, zipper-free volume ramping, global soft mute, per-channel ramp status.

---
 rtl/sdm_dac_bank.sv | 136 +++++++++++++
 tb/tb_sdm_dac_bank.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_dac_bank.sv
// Multi-channel first-order sigma-delta DAC bank. Each channel's output is gated by a volume PWM.
// Channel volume ramps toward its target so that volume changes and soft mute do not cause zipper noise.

module sdm_dac_lane #(
  parameter int SW      = 8,
  parameter int VW      = 6,
  parameter int RAMP_EN = 1
) (
  input  logic          clk32,
  input  logic          rst_n,
  input  logic          smp_we,
  input  logic          vol_we,
  input  logic [SW-1:0] smp_in,
  input  logic [VW-1:0] vol_in,
  input  logic          mute,
  input  logic          ramp_tick,
  input  logic [VW-1:0] vol_cnt,
  input  logic          mid,
  output logic          dac_out,
  output logic          ramp_busy
);

  logic [SW-1:0] sample, acc;
  logic [SW:0]   sum;
  logic [VW-1:0] vol_tgt, vol_cur, eff;
  logic          carry, gate, gate_d;

  assign eff       = mute ? '0 : vol_tgt;
  assign ramp_busy = (vol_cur != eff);
  assign sum       = {1'b0, acc} + {1'b0, sample};

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      sample  <= {1'b1, {(SW-1){1'b0}}};
      vol_tgt <= '0;
      vol_cur <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      gate    <= 1'b0;
      gate_d  <= 1'b0;
    end else begin
      if (smp_we) sample  <= smp_in;
      if (vol_we) vol_tgt <= vol_in;
      // Ramp mode steps one LSB per prescaler wrap, so a retarget simply reverses direction
      if (RAMP_EN == 0)
        vol_cur <= eff;
      else if (ramp_tick && ramp_busy)
        vol_cur <= (vol_cur < eff) ? vol_cur + 1'b1 : vol_cur - 1'b1;
      gate <= (vol_cnt < vol_cur) || (&vol_cur);
      if (gate) {carry, acc} <= sum;
      else      carry        <= 1'b0;
      gate_d <= gate;
    end
  end

  // Gated-off channels idle at midscale (clk/2 square) instead of a DC rail
  assign dac_out = gate_d ? carry : mid;

endmodule

module sdm_dac_bank #(
  parameter int CHANNELS = 4,
  parameter int SW       = 8,
  parameter int VW       = 6,
  parameter int VOL_STEP = 31,
  parameter int RAMP_DIV = 4,
  parameter int RAMP_EN  = 1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW      = (SW > VW) ? SW : VW
) (
  input  logic                clk32,
  input  logic                rst_n,
  input  logic                wr_stb,
  input  logic [CW-1:0]       wr_chan,
  input  logic                wr_sel,
  input  logic                wr_fmt,
  input  logic [DW-1:0]       wr_data,
  input  logic                mute,
  output logic [CHANNELS-1:0] dac_out,
  output logic [CHANNELS-1:0] ramp_busy
);

  localparam int PW                = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(RAMP_DIV - 1);
  localparam logic [VW-1:0] VSTEP  = VW'(VOL_STEP);

  typedef struct packed {
    logic [SW-1:0] smp;
    logic [VW-1:0] vol;
  } wr_req_t;

  wr_req_t             req;
  logic [CHANNELS-1:0] smp_we, vol_we;
  logic [PW-1:0]       prescaler;
  logic [VW-1:0]       vol_cnt;
  logic                mid, ramp_tick;

  // Two's complement becomes offset binary by flipping the sign bit
  assign req.smp   = wr_fmt ? {~wr_data[SW-1], wr_data[SW-2:0]} : wr_data[SW-1:0];
  assign req.vol   = wr_data[VW-1:0];
  assign ramp_tick = (prescaler == PMAX);

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      vol_cnt   <= '0;
      mid       <= 1'b0;
    end else begin
      prescaler <= ramp_tick ? '0 : prescaler + 1'b1;
      vol_cnt   <= vol_cnt + VSTEP;
      mid       <= ~mid;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    // Out-of-range channel numbers match no lane and are dropped
    assign smp_we[c] = wr_stb && !wr_sel && (wr_chan == CW'(c));
    assign vol_we[c] = wr_stb &&  wr_sel && (wr_chan == CW'(c));

    sdm_dac_lane #(.SW(SW), .VW(VW), .RAMP_EN(RAMP_EN)) u_lane (
      .clk32     (clk32),
      .rst_n     (rst_n),
      .smp_we    (smp_we[c]),
      .vol_we    (vol_we[c]),
      .smp_in    (req.smp),
      .vol_in    (req.vol),
      .mute      (mute),
      .ramp_tick (ramp_tick),
      .vol_cnt   (vol_cnt),
      .mid       (mid),
      .dac_out   (dac_out[c]),
      .ramp_busy (ramp_busy[c])
    );
  end

endmodule

// File: tb/tb_sdm_dac_bank.sv
// Directed bench for sdm_dac_bank: default ramped build, a 3-channel build and a no-ramp build.
module tb_sdm_dac_bank;

  logic clk32;
  logic rst_n;
  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  int n_run = 0;
  int n_fail = 0;
  int cyc;

  // Reference for the shared midscale toggle: high after odd edges since reset
  always @(posedge clk32 or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  logic       wr_stb, wr_sel, wr_fmt, mute;
  logic [1:0] wr_chan;
  logic [7:0] wr_data;
  logic [3:0] dac_out, ramp_busy;

  logic       w3_stb, w3_sel, w3_fmt, w3_mute;
  logic [1:0] w3_chan;
  logic [7:0] w3_data;
  logic [2:0] dac3, busy3;

  logic       wn_stb, wn_sel, wn_fmt, wn_mute;
  logic [1:0] wn_chan;
  logic [7:0] wn_data;
  logic [3:0] dacn, busyn;

  sdm_dac_bank #(.CHANNELS(4), .SW(8), .VW(6), .VOL_STEP(31), .RAMP_DIV(4), .RAMP_EN(1)) dut (
    .clk32(clk32), .rst_n(rst_n), .wr_stb(wr_stb), .wr_chan(wr_chan), .wr_sel(wr_sel),
    .wr_fmt(wr_fmt), .wr_data(wr_data), .mute(mute), .dac_out(dac_out), .ramp_busy(ramp_busy));

  sdm_dac_bank #(.CHANNELS(3), .SW(8), .VW(6), .VOL_STEP(31), .RAMP_DIV(4), .RAMP_EN(1)) dut3 (
    .clk32(clk32), .rst_n(rst_n), .wr_stb(w3_stb), .wr_chan(w3_chan), .wr_sel(w3_sel),
    .wr_fmt(w3_fmt), .wr_data(w3_data), .mute(w3_mute), .dac_out(dac3), .ramp_busy(busy3));

  sdm_dac_bank #(.CHANNELS(4), .SW(8), .VW(6), .VOL_STEP(31), .RAMP_DIV(4), .RAMP_EN(0)) dut_nr (
    .clk32(clk32), .rst_n(rst_n), .wr_stb(wn_stb), .wr_chan(wn_chan), .wr_sel(wn_sel),
    .wr_fmt(wn_fmt), .wr_data(wn_data), .mute(wn_mute), .dac_out(dacn), .ramp_busy(busyn));

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic sel, input logic fmt, input logic [7:0] d);
    wr_chan = ch; wr_sel = sel; wr_fmt = fmt; wr_data = d; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0; mute = 1'b0; wr_stb = 1'b0; wr_chan = '0; wr_sel = 1'b0; wr_fmt = 1'b0; wr_data = '0;
    w3_stb = 1'b0; w3_chan = '0; w3_sel = 1'b0; w3_fmt = 1'b0; w3_data = '0; w3_mute = 1'b0;
    wn_stb = 1'b0; wn_chan = '0; wn_sel = 1'b0; wn_fmt = 1'b0; wn_data = '0; wn_mute = 1'b0;
    tick();
    wr(2'd0, 1'b1, 1'b0, 8'h3F);
    wr(2'd1, 1'b0, 1'b1, 8'h12);
    wr(2'd3, 1'b1, 1'b0, 8'h05);
    n_run++;
    if (dac_out !== 4'b0000 || ramp_busy !== 4'b0000) begin
      n_fail++; $display("FAIL reset_main: dac_out=%b busy=%b exp 0000/0000", dac_out, ramp_busy);
    end
    n_run++;
    if (dac3 !== 3'b000 || busy3 !== 3'b000 || dacn !== 4'b0000 || busyn !== 4'b0000) begin
      n_fail++; $display("FAIL reset_aux: dac3=%b busy3=%b dacn=%b busyn=%b exp all 0", dac3, busy3, dacn, busyn);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      n_run++;
      if (dac_out !== exp || ramp_busy !== 4'b0000) begin
        n_fail++; $display("FAIL reset_mid[%0d]: dac_out=%b busy=%b exp %b/0000", i, dac_out, ramp_busy, exp);
      end
    end
  endtask

  task automatic test_ramp_up();
    int cnt, ones;
    wr(2'd0, 1'b0, 1'b0, 8'hC0);
    wr(2'd0, 1'b1, 1'b0, 8'h3F);
    cnt = 0;
    for (int i = 0; i < 400 && ramp_busy[0]; i++) begin cnt++; tick(); end
    n_run++;
    if (cnt < 248 || cnt > 256 || ramp_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL ramp_up_busy: busy cycles=%0d busy=%b exp 248..256 then 0", cnt, ramp_busy[0]);
    end
    n_run++;
    if (dut.g_lane[0].u_lane.vol_cur !== 6'd63) begin
      n_fail++; $display("FAIL ramp_up_vol: vol_cur=%0d exp 63", dut.g_lane[0].u_lane.vol_cur);
    end
    repeat (4) tick();
    ones = 0;
    repeat (256) begin tick(); ones += int'(dac_out[0]); end
    n_run++;
    if (ones != 192) begin
      n_fail++; $display("FAIL ramp_up_duty: ones=%0d exp 192", ones);
    end
  endtask

  task automatic test_format();
    int ones;
    logic [7:0] exp_s [3] = '{8'h40, 8'hC0, 8'h40};
    logic       fmt_s [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] dat_s [3] = '{8'h40, 8'h40, 8'hC0};
    for (int i = 0; i < 3; i++) begin
      wr(2'd1, 1'b0, fmt_s[i], dat_s[i]);
      n_run++;
      if (dut.g_lane[1].u_lane.sample !== exp_s[i]) begin
        n_fail++; $display("FAIL format[%0d]: stored=%h exp %h", i, dut.g_lane[1].u_lane.sample, exp_s[i]);
      end
    end
    wr(2'd1, 1'b0, 1'b1, 8'h40);
    wr(2'd1, 1'b1, 1'b0, 8'h3F);
    for (int i = 0; i < 400 && ramp_busy[1]; i++) tick();
    repeat (4) tick();
    ones = 0;
    repeat (256) begin tick(); ones += int'(dac_out[1]); end
    n_run++;
    if (ones != 192 || ramp_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL format_duty: ones=%0d busy=%b exp 192/0", ones, ramp_busy[1]);
    end
  endtask

  task automatic test_retarget();
    int cnt;
    logic [5:0] vmax;
    wr(2'd2, 1'b1, 1'b0, 8'd63);
    repeat (39) tick();
    wr(2'd2, 1'b1, 1'b0, 8'd5);
    n_run++;
    if (dut.g_lane[2].u_lane.vol_cur !== 6'd10) begin
      n_fail++; $display("FAIL retarget_start: vol_cur=%0d exp 10", dut.g_lane[2].u_lane.vol_cur);
    end
    vmax = dut.g_lane[2].u_lane.vol_cur;
    cnt = 0;
    for (int i = 0; i < 40 && ramp_busy[2]; i++) begin
      cnt++; tick();
      if (dut.g_lane[2].u_lane.vol_cur > vmax) vmax = dut.g_lane[2].u_lane.vol_cur;
    end
    n_run++;
    if (cnt < 16 || cnt > 20 || vmax > 6'd10) begin
      n_fail++; $display("FAIL retarget_ramp: busy cycles=%0d max vol=%0d exp 16..20 and <=10", cnt, vmax);
    end
    n_run++;
    if (dut.g_lane[2].u_lane.vol_cur !== 6'd5 || ramp_busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL retarget_end: vol_cur=%0d busy=%b exp 5/0", dut.g_lane[2].u_lane.vol_cur, ramp_busy[2]);
    end
  endtask

  task automatic test_mute();
    wr(2'd3, 1'b1, 1'b0, 8'd63);
    for (int i = 0; i < 400 && ramp_busy[3]; i++) tick();
    mute = 1'b1;
    #1;
    n_run++;
    if (ramp_busy !== 4'b1111) begin
      n_fail++; $display("FAIL mute_busy: busy=%b exp 1111", ramp_busy);
    end
    for (int i = 0; i < 400 && ramp_busy != 4'b0000; i++) tick();
    n_run++;
    if (ramp_busy !== 4'b0000 || dut.g_lane[3].u_lane.vol_cur !== 6'd0) begin
      n_fail++; $display("FAIL mute_down: busy=%b vol3=%0d exp 0000/0", ramp_busy, dut.g_lane[3].u_lane.vol_cur);
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++;
      if (dac_out !== {4{cyc[0]}}) begin
        n_fail++; $display("FAIL mute_mid[%0d]: dac_out=%b exp %b", i, dac_out, {4{cyc[0]}});
      end
    end
    mute = 1'b0;
    #1;
    n_run++;
    if (ramp_busy !== 4'b1111) begin
      n_fail++; $display("FAIL unmute_busy: busy=%b exp 1111", ramp_busy);
    end
    for (int i = 0; i < 400 && ramp_busy != 4'b0000; i++) tick();
    n_run++;
    if (ramp_busy !== 4'b0000 || dut.g_lane[3].u_lane.vol_cur !== 6'd63 || dut.g_lane[2].u_lane.vol_cur !== 6'd5) begin
      n_fail++; $display("FAIL unmute_up: busy=%b vol3=%0d vol2=%0d exp 0000/63/5", ramp_busy,
                         dut.g_lane[3].u_lane.vol_cur, dut.g_lane[2].u_lane.vol_cur);
    end
  endtask

  task automatic test_back_to_back();
    int ones;
    wr(2'd0, 1'b0, 1'b0, 8'h40);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (i % 16 == 7) wr(2'd0, 1'b0, 1'b0, 8'h40);
      else             tick();
      ones += int'(dac_out[0]);
    end
    n_run++;
    if (ones != 64) begin
      n_fail++; $display("FAIL rewrite_duty: ones=%0d exp 64", ones);
    end
    wr(2'd0, 1'b0, 1'b1, 8'h81);
    ones = 0;
    repeat (256) begin tick(); ones += int'(dac_out[0]); end
    n_run++;
    if (ones != 1) begin
      n_fail++; $display("FAIL small_duty: ones=%0d exp 1", ones);
    end
  endtask

  task automatic test_chan_range();
    logic bad;
    w3_chan = 2'd3; w3_sel = 1'b1; w3_data = 8'd63; w3_stb = 1'b1; tick();
    w3_sel = 1'b0; w3_data = 8'hFF; tick();
    w3_stb = 1'b0;
    bad = 1'b0;
    repeat (8) begin tick(); if (busy3 !== 3'b000) bad = 1'b1; end
    n_run++;
    if (bad) begin
      n_fail++; $display("FAIL range_busy: busy3=%b exp 000", busy3);
    end
    n_run++;
    if (dut3.g_lane[0].u_lane.vol_tgt !== 6'd0 || dut3.g_lane[1].u_lane.vol_tgt !== 6'd0 ||
        dut3.g_lane[2].u_lane.vol_tgt !== 6'd0 || dut3.g_lane[0].u_lane.sample !== 8'h80 ||
        dut3.g_lane[1].u_lane.sample !== 8'h80 || dut3.g_lane[2].u_lane.sample !== 8'h80) begin
      n_fail++; $display("FAIL range_regs: tgt2=%0d smp2=%h exp 0/80", dut3.g_lane[2].u_lane.vol_tgt, dut3.g_lane[2].u_lane.sample);
    end
    w3_chan = 2'd2; w3_sel = 1'b1; w3_data = 8'd7; w3_stb = 1'b1; tick();
    w3_stb = 1'b0;
    n_run++;
    if (busy3 !== 3'b100) begin
      n_fail++; $display("FAIL range_valid: busy3=%b exp 100", busy3);
    end
  endtask

  task automatic test_no_ramp();
    int g;
    wn_chan = 2'd0; wn_sel = 1'b1; wn_data = 8'd20; wn_stb = 1'b1; tick();
    wn_stb = 1'b0;
    n_run++;
    if (busyn !== 4'b0001) begin
      n_fail++; $display("FAIL noramp_pulse: busy=%b exp 0001", busyn);
    end
    tick();
    n_run++;
    if (busyn !== 4'b0000 || dut_nr.g_lane[0].u_lane.vol_cur !== 6'd20) begin
      n_fail++; $display("FAIL noramp_follow: busy=%b vol=%0d exp 0000/20", busyn, dut_nr.g_lane[0].u_lane.vol_cur);
    end
    tick();
    g = 0;
    repeat (64) begin tick(); g += int'(dut_nr.g_lane[0].u_lane.gate); end
    n_run++;
    if (g != 20) begin
      n_fail++; $display("FAIL noramp_gate: gate high=%0d exp 20", g);
    end
  endtask

  task automatic test_async_reset();
    wr(2'd0, 1'b1, 1'b0, 8'd0);
    repeat (3) tick();
    n_run++;
    if (ramp_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: busy0=%b exp 1", ramp_busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (dac_out !== 4'b0000 || ramp_busy !== 4'b0000 || dut.g_lane[0].u_lane.vol_cur !== 6'd0 ||
        dut.g_lane[0].u_lane.sample !== 8'h80 || dacn !== 4'b0000 || busy3 !== 3'b000) begin
      n_fail++; $display("FAIL areset_now: dac=%b busy=%b vol0=%0d smp0=%h exp 0000/0000/0/80",
                         dac_out, ramp_busy, dut.g_lane[0].u_lane.vol_cur, dut.g_lane[0].u_lane.sample);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_format();
    test_retarget();
    test_mute();
    test_back_to_back();
    test_chan_range();
    test_no_ramp();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
